// File: rtl/res_station_pool.sv
// Reservation-station pool: N_ENTRIES stations, one dispatch port, one issue port, CDB snoop/free.
// Optional macro RS_FLUSH_EN adds a synchronous Flush input that frees every entry.
module res_station_pool #(
    parameter int unsigned N_ENTRIES = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TAG_W     = 3,
    parameter int unsigned OP_W      = 3,
    parameter int unsigned TAG_BASE  = 1
) (
    input  logic                           Clock,
    input  logic                           Reset,
`ifdef RS_FLUSH_EN
    input  logic                           Flush,
`endif
    input  logic                           Disp_valid,
    output logic                           Disp_ready,
    input  logic [OP_W-1:0]                Disp_op,
    input  logic [DATA_W-1:0]              Disp_Vj,
    input  logic [DATA_W-1:0]              Disp_Vk,
    input  logic [TAG_W-1:0]               Disp_Qj,
    input  logic [TAG_W-1:0]               Disp_Qk,
    output logic [TAG_W-1:0]               Disp_tag,
    input  logic                           CDB_valid,
    input  logic [TAG_W-1:0]               CDB_tag,
    input  logic [DATA_W-1:0]              CDB_data,
    output logic                           Issue_valid,
    input  logic                           Issue_ready,
    output logic [OP_W-1:0]                Issue_op,
    output logic [DATA_W-1:0]              Issue_A,
    output logic [DATA_W-1:0]              Issue_B,
    output logic [TAG_W-1:0]               Issue_tag,
    output logic [N_ENTRIES-1:0]           Busy_vec,
    output logic [$clog2(N_ENTRIES+1)-1:0] Free_count
);

    localparam int unsigned IDX_W = $clog2(N_ENTRIES);
    localparam int unsigned CNT_W = $clog2(N_ENTRIES + 1);

    typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_EXEC} ent_state_t;

    ent_state_t          st   [N_ENTRIES];
    logic [OP_W-1:0]     op_q [N_ENTRIES];
    logic [DATA_W-1:0]   vj_q [N_ENTRIES];
    logic [DATA_W-1:0]   vk_q [N_ENTRIES];
    logic [TAG_W-1:0]    qj_q [N_ENTRIES];
    logic [TAG_W-1:0]    qk_q [N_ENTRIES];

    logic                lock_valid;
    logic [IDX_W-1:0]    lock_idx;
    logic [IDX_W-1:0]    rr_ptr;

    logic                disp_found;
    logic [IDX_W-1:0]    disp_idx;
    logic [CNT_W-1:0]    free_cnt;
    logic [N_ENTRIES-1:0] busy;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    cand;
    logic                dispatch;
    logic                handshake;
    logic                cdb_ok;
    logic                byp_j;
    logic                byp_k;

    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        free_cnt   = '0;
        busy       = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            busy[i] = (st[i] != S_FREE);
            if (st[i] == S_FREE) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!disp_found) begin
                    disp_found = 1'b1;
                    disp_idx   = IDX_W'(i);
                end
            end
        end
    end

    // A locked offer holds until handshake; otherwise scan READY entries from rr_ptr.
    always_comb begin
        sel_found = lock_valid;
        sel_idx   = lock_idx;
        cand      = '0;
        if (!lock_valid) begin
            for (int unsigned k = 0; k < N_ENTRIES; k++) begin
                cand = IDX_W'((32'(rr_ptr) + k) % N_ENTRIES);
                if (!sel_found && st[cand] == S_READY) begin
                    sel_found = 1'b1;
                    sel_idx   = cand;
                end
            end
        end
    end

    assign dispatch  = Disp_valid && disp_found;
    assign handshake = sel_found && Issue_ready;
    assign cdb_ok    = CDB_valid && (CDB_tag != '0);
    assign byp_j     = cdb_ok && (Disp_Qj == CDB_tag);
    assign byp_k     = cdb_ok && (Disp_Qk == CDB_tag);

    assign Disp_ready  = disp_found;
    assign Disp_tag    = disp_found ? TAG_W'(TAG_BASE) + TAG_W'(disp_idx) : '0;
    assign Issue_valid = sel_found;
    assign Issue_op    = sel_found ? op_q[sel_idx] : '0;
    assign Issue_A     = sel_found ? vj_q[sel_idx] : '0;
    assign Issue_B     = sel_found ? vk_q[sel_idx] : '0;
    assign Issue_tag   = sel_found ? TAG_W'(TAG_BASE) + TAG_W'(sel_idx) : '0;
    assign Busy_vec    = busy;
    assign Free_count  = free_cnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                st[i]   <= S_FREE;
                op_q[i] <= '0;
                vj_q[i] <= '0;
                vk_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
            end
            lock_valid <= 1'b0;
            lock_idx   <= '0;
            rr_ptr     <= '0;
        end
`ifdef RS_FLUSH_EN
        else if (Flush) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                st[i] <= S_FREE;
            end
            lock_valid <= 1'b0;
            lock_idx   <= '0;
            rr_ptr     <= '0;
        end
`endif
        else begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                case (st[i])
                    S_FREE: begin
                        if (dispatch && disp_idx == IDX_W'(i)) begin
                            st[i]   <= S_WAIT;
                            op_q[i] <= Disp_op;
                            vj_q[i] <= byp_j ? CDB_data : Disp_Vj;
                            vk_q[i] <= byp_k ? CDB_data : Disp_Vk;
                            qj_q[i] <= byp_j ? '0 : Disp_Qj;
                            qk_q[i] <= byp_k ? '0 : Disp_Qk;
                        end
                    end
                    S_WAIT: begin
                        if (qj_q[i] == '0 && qk_q[i] == '0) begin
                            st[i] <= S_READY;
                        end
                        if (cdb_ok && qj_q[i] == CDB_tag) begin
                            vj_q[i] <= CDB_data;
                            qj_q[i] <= '0;
                        end
                        if (cdb_ok && qk_q[i] == CDB_tag) begin
                            vk_q[i] <= CDB_data;
                            qk_q[i] <= '0;
                        end
                    end
                    S_READY: begin
                        if (handshake && sel_idx == IDX_W'(i)) begin
                            st[i] <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (CDB_valid && CDB_tag == TAG_W'(TAG_BASE + i)) begin
                            st[i] <= S_FREE;
                        end
                    end
                    default: st[i] <= S_FREE;
                endcase
            end
            if (handshake) begin
                lock_valid <= 1'b0;
                rr_ptr     <= (sel_idx == IDX_W'(N_ENTRIES - 1)) ? '0 : sel_idx + 1'b1;
            end else if (sel_found) begin
                lock_valid <= 1'b1;
                lock_idx   <= sel_idx;
            end
        end
    end

endmodule
